// File: rtl/sdram_arbit_if.sv
// Bundle between the SDRAM bus arbiter and its four requesters plus the SDRAM pins.
// master is the arbiter's view; slave is the requester/pin-side view.
interface sdram_arbit_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16
);
  logic [3:0]        init_cmd;
  logic [ADDR_W-1:0] init_addr;
  logic              flag_init_end;

  logic              ref_req;
  logic [3:0]        ref_cmd;
  logic [ADDR_W-1:0] ref_addr;
  logic              flag_ref_end;
  logic              ref_en;

  logic              wr_req;
  logic [3:0]        wr_cmd;
  logic [ADDR_W-1:0] wr_addr;
  logic [1:0]        wr_bank;
  logic [DATA_W-1:0] wr_data;
  logic              flag_wr_end;
  logic              wr_en;

  logic              rd_req;
  logic [3:0]        rd_cmd;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        rd_bank;
  logic              flag_rd_end;
  logic              rd_en;

  logic              sdram_cke;
  logic [3:0]        sdram_cmd;
  logic [1:0]        sdram_ba;
  logic [ADDR_W-1:0] sdram_addr;
  logic [DATA_W-1:0] sdram_dq_out;
  logic              sdram_dq_oe;
  logic              arb_err;

  modport master (
    input  init_cmd, init_addr, flag_init_end,
    input  ref_req, ref_cmd, ref_addr, flag_ref_end,
    input  wr_req, wr_cmd, wr_addr, wr_bank, wr_data, flag_wr_end,
    input  rd_req, rd_cmd, rd_addr, rd_bank, flag_rd_end,
    output ref_en, wr_en, rd_en,
    output sdram_cke, sdram_cmd, sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe, arb_err
  );

  modport slave (
    output init_cmd, init_addr, flag_init_end,
    output ref_req, ref_cmd, ref_addr, flag_ref_end,
    output wr_req, wr_cmd, wr_addr, wr_bank, wr_data, flag_wr_end,
    output rd_req, rd_cmd, rd_addr, rd_bank, flag_rd_end,
    input  ref_en, wr_en, rd_en,
    input  sdram_cke, sdram_cmd, sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe, arb_err
  );
endinterface

// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter: shares the command/address/data pins between init, refresh,
// write and read engines, with refresh priority, write/read alternation and a watchdog.
module sdram_arbit #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MAX_OWN = 1023
) (
  input  logic          sclk,
  input  logic          reset,
  sdram_arbit_if.master bus
);

  localparam logic [3:0] CmdNop   = 4'b0111;
  localparam logic [9:0] OwnLimit = 10'(MAX_OWN - 1);

  typedef enum logic [4:0] {
    StInit  = 5'b00001,
    StArbit = 5'b00010,
    StAref  = 5'b00100,
    StWrite = 5'b01000,
    StRead  = 5'b10000
  } state_e;

  typedef enum logic {
    GrWrite = 1'b0,
    GrRead  = 1'b1
  } grant_e;

  state_e      state_q;
  grant_e      last_grant_q;
  logic [9:0]  own_cnt_q;
  logic        ref_en_q, wr_en_q, rd_en_q;
  logic        arb_err_q;
  logic        cke_q;
  logic        owner_end;

  logic [3:0]        cmd_mux;
  logic [ADDR_W-1:0] addr_mux;
  logic [1:0]        ba_mux;

  // Only the current owner's end flag counts; others are ignored.
  always_comb begin
    owner_end = 1'b0;
    unique case (state_q)
      StAref:  owner_end = bus.flag_ref_end;
      StWrite: owner_end = bus.flag_wr_end;
      StRead:  owner_end = bus.flag_rd_end;
      default: owner_end = 1'b0;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (!reset) begin
      state_q      <= StInit;
      last_grant_q <= GrRead;
      own_cnt_q    <= '0;
      ref_en_q     <= 1'b0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      arb_err_q    <= 1'b0;
      cke_q        <= 1'b0;
    end else begin
      cke_q    <= 1'b1;
      ref_en_q <= 1'b0;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      unique case (state_q)
        StInit: begin
          own_cnt_q <= '0;
          if (bus.flag_init_end) state_q <= StArbit;
        end
        StArbit: begin
          own_cnt_q <= '0;
          if (bus.ref_req) begin
            state_q  <= StAref;
            ref_en_q <= 1'b1;
          end else if (bus.wr_req && (!bus.rd_req || last_grant_q == GrRead)) begin
            state_q      <= StWrite;
            wr_en_q      <= 1'b1;
            last_grant_q <= GrWrite;
          end else if (bus.rd_req) begin
            state_q      <= StRead;
            rd_en_q      <= 1'b1;
            last_grant_q <= GrRead;
          end
        end
        StAref, StWrite, StRead: begin
          // End flag beats a coincident timeout.
          if (owner_end) begin
            state_q <= StArbit;
          end else if (own_cnt_q == OwnLimit) begin
            state_q   <= StArbit;
            arb_err_q <= 1'b1;
          end else begin
            own_cnt_q <= own_cnt_q + 10'd1;
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

  // Pins follow the owner with no added latency; everything else sees NOP.
  always_comb begin
    cmd_mux  = CmdNop;
    addr_mux = '0;
    ba_mux   = '0;
    unique case (state_q)
      StInit: begin
        cmd_mux  = bus.init_cmd;
        addr_mux = bus.init_addr;
      end
      StAref: begin
        cmd_mux  = bus.ref_cmd;
        addr_mux = bus.ref_addr;
      end
      StWrite: begin
        cmd_mux  = bus.wr_cmd;
        addr_mux = bus.wr_addr;
        ba_mux   = bus.wr_bank;
      end
      StRead: begin
        cmd_mux  = bus.rd_cmd;
        addr_mux = bus.rd_addr;
        ba_mux   = bus.rd_bank;
      end
      default: begin
        cmd_mux  = CmdNop;
        addr_mux = '0;
        ba_mux   = '0;
      end
    endcase
  end

  assign bus.ref_en       = ref_en_q;
  assign bus.wr_en        = wr_en_q;
  assign bus.rd_en        = rd_en_q;
  assign bus.arb_err      = arb_err_q;
  assign bus.sdram_cke    = cke_q;
  assign bus.sdram_cmd    = cmd_mux;
  assign bus.sdram_addr   = addr_mux;
  assign bus.sdram_ba     = ba_mux;
  assign bus.sdram_dq_out = bus.wr_data[DATA_W-1:0];
  assign bus.sdram_dq_oe  = (state_q == StWrite);

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit: init pass-through, priority, alternation,
// preemption hand-off, watchdog timeout and reset abort.
module tb_sdram_arbit;

  localparam logic [3:0]  NOP   = 4'b0111;
  localparam logic [3:0]  ICMD  = 4'b0010;
  localparam logic [3:0]  RCMD  = 4'b0001;
  localparam logic [3:0]  WCMD  = 4'b0100;
  localparam logic [3:0]  DCMD  = 4'b0101;
  localparam logic [11:0] IADDR = 12'h400;
  localparam logic [11:0] RADDR = 12'h0aa;
  localparam logic [11:0] WADDR = 12'h123;
  localparam logic [11:0] DADDR = 12'h321;
  localparam logic [1:0]  WBANK = 2'd2;
  localparam logic [1:0]  DBANK = 2'd1;
  localparam logic [15:0] WDATA = 16'hbeef;

  logic sclk;
  logic reset;
  int   checks;
  int   errors;

  sdram_arbit_if #(.ADDR_W(12), .DATA_W(16)) bus ();

  sdram_arbit #(.ADDR_W(12), .DATA_W(16), .MAX_OWN(15)) dut (
    .sclk  (sclk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic tick();
    @(posedge sclk);
    #2;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_en(input string tag, input logic r, input logic w, input logic d);
    logic [2:0] obs;
    logic [2:0] exp;
    obs = {bus.ref_en, bus.wr_en, bus.rd_en};
    exp = {r, w, d};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: {ref,wr,rd}_en got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_pins(input string tag, input logic [3:0] c, input logic [11:0] a,
                          input logic [1:0] b, input logic oe);
    logic [34:0] obs;
    logic [34:0] exp;
    obs = {bus.sdram_cmd, bus.sdram_addr, bus.sdram_ba, bus.sdram_dq_oe, bus.sdram_dq_out};
    exp = {c, a, b, oe, WDATA};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: {cmd,addr,ba,oe,dq} got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus.init_cmd = ICMD;  bus.init_addr = IADDR; bus.flag_init_end = 1'b0;
    bus.ref_req  = 1'b0;  bus.ref_cmd   = RCMD;  bus.ref_addr = RADDR; bus.flag_ref_end = 1'b0;
    bus.wr_req   = 1'b0;  bus.wr_cmd    = WCMD;  bus.wr_addr  = WADDR; bus.wr_bank = WBANK;
    bus.wr_data  = WDATA; bus.flag_wr_end = 1'b0;
    bus.rd_req   = 1'b0;  bus.rd_cmd    = DCMD;  bus.rd_addr  = DADDR; bus.rd_bank = DBANK;
    bus.flag_rd_end = 1'b0;

    // Reset state
    tick();
    tick();
    chk_bit("rst_cke", bus.sdram_cke, 1'b0);
    chk_en("rst_en", 1'b0, 1'b0, 1'b0);
    chk_bit("rst_err", bus.arb_err, 1'b0);
    chk_pins("rst_pins", ICMD, IADDR, 2'd0, 1'b0);

    // INIT ignores requests and passes init pins through
    reset      = 1'b1;
    bus.wr_req = 1'b1;
    tick();
    chk_bit("cke_up", bus.sdram_cke, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_en("init_ignore", 1'b0, 1'b0, 1'b0);
      chk_pins("init_pins", ICMD, IADDR, 2'd0, 1'b0);
    end
    bus.wr_req        = 1'b0;
    bus.flag_init_end = 1'b1;
    tick();
    bus.flag_init_end = 1'b0;
    chk_pins("arbit_nop", NOP, 12'd0, 2'd0, 1'b0);
    chk_en("arbit_en", 1'b0, 1'b0, 1'b0);
    tick();
    chk_pins("arbit_idle", NOP, 12'd0, 2'd0, 1'b0);

    // All three pending: refresh, then write (last_grant=READ), then read
    bus.ref_req = 1'b1; bus.wr_req = 1'b1; bus.rd_req = 1'b1;
    tick();
    chk_en("pri_ref", 1'b1, 1'b0, 1'b0);
    chk_pins("pri_ref_pins", RCMD, RADDR, 2'd0, 1'b0);
    bus.ref_req      = 1'b0;
    bus.flag_ref_end = 1'b1;
    tick();
    bus.flag_ref_end = 1'b0;
    chk_en("pri_gap1", 1'b0, 1'b0, 1'b0);
    chk_pins("pri_gap1_pins", NOP, 12'd0, 2'd0, 1'b0);
    tick();
    chk_en("pri_wr", 1'b0, 1'b1, 1'b0);
    chk_pins("pri_wr_pins", WCMD, WADDR, WBANK, 1'b1);
    bus.wr_req      = 1'b0;
    bus.flag_wr_end = 1'b1;
    tick();
    bus.flag_wr_end = 1'b0;
    chk_pins("pri_gap2_pins", NOP, 12'd0, 2'd0, 1'b0);
    tick();
    chk_en("pri_rd", 1'b0, 1'b0, 1'b1);
    chk_pins("pri_rd_pins", DCMD, DADDR, DBANK, 1'b0);
    bus.rd_req      = 1'b0;
    bus.flag_rd_end = 1'b1;
    tick();
    bus.flag_rd_end = 1'b0;

    // Lone write: one-cycle wr_en, held ownership, then NOP
    bus.wr_req = 1'b1;
    tick();
    chk_en("wr_grant", 1'b0, 1'b1, 1'b0);
    bus.wr_req = 1'b0;
    tick();
    chk_en("wr_en_once", 1'b0, 1'b0, 1'b0);
    chk_pins("wr_hold_pins", WCMD, WADDR, WBANK, 1'b1);
    bus.flag_wr_end = 1'b1;
    tick();
    bus.flag_wr_end = 1'b0;
    chk_pins("wr_done_pins", NOP, 12'd0, 2'd0, 1'b0);

    // Alternation with both held; last grant was WRITE so READ goes first
    bus.wr_req = 1'b1;
    bus.rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic exp_rd;
      exp_rd = (i % 2 == 0);
      tick();
      chk_en("alt_grant", 1'b0, ~exp_rd, exp_rd);
      repeat (7) tick();
      if (exp_rd) bus.flag_rd_end = 1'b1;
      else        bus.flag_wr_end = 1'b1;
      tick();
      bus.flag_rd_end = 1'b0;
      bus.flag_wr_end = 1'b0;
      chk_pins("alt_gap", NOP, 12'd0, 2'd0, 1'b0);
    end
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    tick();
    chk_en("alt_idle", 1'b0, 1'b0, 1'b0);

    // Refresh request mid-write: no preemption until engine ends and re-requests
    bus.wr_req = 1'b1;
    tick();
    chk_en("pre_wr", 1'b0, 1'b1, 1'b0);
    tick();
    bus.ref_req = 1'b1;
    tick();
    chk_pins("pre_hold", WCMD, WADDR, WBANK, 1'b1);
    chk_en("pre_noref", 1'b0, 1'b0, 1'b0);
    bus.flag_wr_end = 1'b1;
    tick();
    bus.flag_wr_end = 1'b0;
    chk_pins("pre_gap", NOP, 12'd0, 2'd0, 1'b0);
    tick();
    chk_en("pre_ref", 1'b1, 1'b0, 1'b0);
    bus.ref_req      = 1'b0;
    bus.flag_ref_end = 1'b1;
    tick();
    bus.flag_ref_end = 1'b0;
    tick();
    chk_en("pre_wr_again", 1'b0, 1'b1, 1'b0);
    bus.wr_req      = 1'b0;
    bus.flag_wr_end = 1'b1;
    tick();
    bus.flag_wr_end = 1'b0;

    // Watchdog: write never ends; stray read end ignored; timeout after 15 cycles
    bus.wr_req = 1'b1;
    tick();
    chk_en("wd_grant", 1'b0, 1'b1, 1'b0);
    bus.wr_req = 1'b0;
    for (int j = 2; j <= 15; j++) begin
      tick();
      bus.flag_rd_end = (j == 4);
      chk_bit("wd_owning", bus.sdram_dq_oe, 1'b1);
    end
    chk_bit("wd_no_err_yet", bus.arb_err, 1'b0);
    tick();
    chk_pins("wd_timeout_pins", NOP, 12'd0, 2'd0, 1'b0);
    chk_bit("wd_err", bus.arb_err, 1'b1);
    tick();
    tick();
    chk_bit("wd_err_sticky", bus.arb_err, 1'b1);
    bus.rd_req = 1'b1;
    tick();
    chk_en("wd_rd_after", 1'b0, 1'b0, 1'b1);
    chk_bit("wd_err_sticky2", bus.arb_err, 1'b1);
    bus.rd_req      = 1'b0;
    bus.flag_rd_end = 1'b1;
    tick();
    bus.flag_rd_end = 1'b0;

    // Reset while owning aborts immediately and clears the error
    bus.wr_req = 1'b1;
    tick();
    chk_en("abort_grant", 1'b0, 1'b1, 1'b0);
    bus.wr_req = 1'b0;
    reset      = 1'b0;
    tick();
    chk_pins("abort_pins", ICMD, IADDR, 2'd0, 1'b0);
    chk_bit("abort_err", bus.arb_err, 1'b0);
    chk_bit("abort_cke", bus.sdram_cke, 1'b0);
    reset             = 1'b1;
    bus.flag_init_end = 1'b1;
    tick();
    bus.flag_init_end = 1'b0;
    chk_bit("reinit_cke", bus.sdram_cke, 1'b1);
    chk_pins("reinit_nop", NOP, 12'd0, 2'd0, 1'b0);

    // End flag coinciding with timeout wins: no error
    bus.wr_req = 1'b1;
    tick();
    chk_en("coin_grant", 1'b0, 1'b1, 1'b0);
    bus.wr_req = 1'b0;
    for (int j = 2; j <= 15; j++) tick();
    bus.flag_wr_end = 1'b1;
    tick();
    bus.flag_wr_end = 1'b0;
    chk_pins("coin_pins", NOP, 12'd0, 2'd0, 1'b0);
    chk_bit("coin_no_err", bus.arb_err, 1'b0);
    tick();
    chk_bit("coin_no_err2", bus.arb_err, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
